snoopy_bus_arbiter: RTL and testbench



---
 rtl/snoopy_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_snoopy_bus_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/snoopy_bus_arbiter.sv
// Round-robin owner arbiter for the shared snoopy bus, with one idle turnaround cycle between owners.
// Define SNOOPY_BUS_ARBITER_TIMEOUT_EN to forcibly revoke an owner after MAX_HOLD_CYCLES granted cycles.
module snoopy_bus_arbiter #(
  parameter int NUMBER_OF_REQUESTERS = 4,
  parameter int MAX_HOLD_CYCLES      = 64
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUMBER_OF_REQUESTERS-1:0]         request,
  output logic [NUMBER_OF_REQUESTERS-1:0]         grant,
  output logic [$clog2(NUMBER_OF_REQUESTERS)-1:0] grantedIndex,
  output logic                                    busy,
  output logic                                    timeout
);

  localparam int IDX_W = $clog2(NUMBER_OF_REQUESTERS);

  if (NUMBER_OF_REQUESTERS < 2 || NUMBER_OF_REQUESTERS > 16) begin : g_bad_n
    $error("NUMBER_OF_REQUESTERS must be in 2..16");
  end
  if (MAX_HOLD_CYCLES < 2) begin : g_bad_hold
    $error("MAX_HOLD_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;

  state_t                            r_state;
  logic [NUMBER_OF_REQUESTERS-1:0]   r_grant;
  logic [IDX_W-1:0]                  r_grantedIndex;
  logic [IDX_W-1:0]                  r_lastWinner;
  logic                              r_busy;

  logic                              w_any;
  logic                              w_hiFound;
  logic [IDX_W-1:0]                  w_hiIdx;
  logic [IDX_W-1:0]                  w_loIdx;
  logic [IDX_W-1:0]                  w_winner;
  logic [NUMBER_OF_REQUESTERS-1:0]   w_winnerOneHot;

  // Lowest requester above lastWinner wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    w_hiFound = 1'b0;
    w_hiIdx   = '0;
    w_loIdx   = '0;
    for (int i = NUMBER_OF_REQUESTERS - 1; i >= 0; i--) begin
      if (request[i]) begin
        if (i > int'(r_lastWinner)) begin
          w_hiFound = 1'b1;
          w_hiIdx   = IDX_W'(i);
        end else begin
          w_loIdx = IDX_W'(i);
        end
      end
    end
    w_winner       = w_hiFound ? w_hiIdx : w_loIdx;
    w_any          = |request;
    w_winnerOneHot = {{(NUMBER_OF_REQUESTERS-1){1'b0}}, 1'b1} << w_winner;
  end

`ifdef SNOOPY_BUS_ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD_CYCLES);
  logic [HOLD_W-1:0] r_holdCount;
  logic              r_timeout;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_grant        <= '0;
      r_grantedIndex <= '0;
      r_busy         <= 1'b0;
      r_lastWinner   <= IDX_W'(NUMBER_OF_REQUESTERS - 1);
`ifdef SNOOPY_BUS_ARBITER_TIMEOUT_EN
      r_holdCount    <= '0;
      r_timeout      <= 1'b0;
`endif
    end else begin
`ifdef SNOOPY_BUS_ARBITER_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE, RELEASE: begin
          if (w_any) begin
            r_state        <= GRANTED;
            r_grant        <= w_winnerOneHot;
            r_grantedIndex <= w_winner;
            r_busy         <= 1'b1;
            r_lastWinner   <= w_winner;
`ifdef SNOOPY_BUS_ARBITER_TIMEOUT_EN
            r_holdCount    <= '0;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        GRANTED: begin
          if (!request[r_grantedIndex]) begin
            r_state        <= RELEASE;
            r_grant        <= '0;
            r_grantedIndex <= '0;
            r_busy         <= 1'b0;
          end
`ifdef SNOOPY_BUS_ARBITER_TIMEOUT_EN
          else if (r_holdCount == HOLD_W'(MAX_HOLD_CYCLES - 1)) begin
            r_state        <= RELEASE;
            r_grant        <= '0;
            r_grantedIndex <= '0;
            r_busy         <= 1'b0;
            r_timeout      <= 1'b1;
          end else begin
            r_holdCount <= r_holdCount + 1'b1;
          end
`endif
        end
        default: begin
          r_state        <= IDLE;
          r_grant        <= '0;
          r_grantedIndex <= '0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

  assign grant        = r_grant;
  assign grantedIndex = r_grantedIndex;
  assign busy         = r_busy;

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Directed bench for snoopy_bus_arbiter with four requesters and an 8-cycle hold limit.
module tb_snoopy_bus_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] request;
  logic [3:0] grant;
  logic [1:0] grantedIndex;
  logic       busy;
  logic       timeout;

  int n_total = 0;
  int n_bad   = 0;

  snoopy_bus_arbiter #(
    .NUMBER_OF_REQUESTERS(4),
    .MAX_HOLD_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .request(request),
    .grant(grant),
    .grantedIndex(grantedIndex),
    .busy(busy),
    .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".grant"}, 32'(grant), 32'h0);
    check({tag, ".busy"},  32'(busy),  32'h0);
    check({tag, ".index"}, 32'(grantedIndex), 32'h0);
  endtask

  initial begin
    logic [3:0] exp_g;
    reset   = 1'b1;
    request = 4'b1111;
    tick();
    check_idle("reset");
    check("reset.timeout", 32'(timeout), 32'h0);

    reset = 1'b0;
    tick();
    check("after_reset.grant", 32'(grant), 32'h1);

    reset   = 1'b1;
    request = 4'b0000;
    tick();
    reset = 1'b0;
    tick();
    check_idle("reidle");

    request = 4'b1010;
    tick();
    check("r1010.grant", 32'(grant), 32'b0010);
    check("r1010.index", 32'(grantedIndex), 32'd1);
    check("r1010.busy",  32'(busy), 32'd1);
    request = 4'b1000;
    tick();
    check_idle("r1010.turnaround");
    tick();
    check("r1010.next.grant", 32'(grant), 32'b1000);
    check("r1010.next.index", 32'(grantedIndex), 32'd3);

    request = 4'b0000;
    tick();
    tick();
    check_idle("rr.start");

    // All four contend; each holds 3 cycles, drops for one edge, then re-raises.
    request = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      for (int c = 0; c < 3; c++) begin
        check($sformatf("rr%0d.hold%0d", k, c), 32'(grant), 32'(exp_g));
        if (c < 2) tick();
      end
      check($sformatf("rr%0d.index", k), 32'(grantedIndex), 32'(k % 4));
      request = request & ~exp_g;
      tick();
      check_idle($sformatf("rr%0d.gap", k));
      request = 4'b1111;
      tick();
    end
    check("rr.after.grant", 32'(grant), 32'b0010);

    request = 4'b0000;
    tick();
    tick();

    request = 4'b0100;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("solo%0d.grant", k), 32'(grant), 32'b0100);
      request = 4'b0000;
      tick();
      check($sformatf("solo%0d.gap", k), 32'(grant), 32'h0);
      request = 4'b0100;
      tick();
    end
    check("solo.final.grant", 32'(grant), 32'b0100);

    reset = 1'b1;
    tick();
    check_idle("reset_in_granted");
    reset   = 1'b0;
    request = 4'b0110;
    tick();
    check("ptr_reset.grant", 32'(grant), 32'b0010);
    check("ptr_reset.index", 32'(grantedIndex), 32'd1);

    request = 4'b0000;
    tick();
    tick();

    request = 4'b0011;
    tick();
`ifdef SNOOPY_BUS_ARBITER_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      check($sformatf("hold%0d.grant", c), 32'(grant), 32'b0001);
      check($sformatf("hold%0d.timeout", c), 32'(timeout), 32'h0);
      tick();
    end
    check("revoke.grant",   32'(grant), 32'h0);
    check("revoke.timeout", 32'(timeout), 32'h1);
    tick();
    check("after_revoke.grant",   32'(grant), 32'b0010);
    check("after_revoke.timeout", 32'(timeout), 32'h0);
`else
    for (int c = 0; c < 12; c++) begin
      check($sformatf("hold%0d.grant", c), 32'(grant), 32'b0001);
      check($sformatf("hold%0d.timeout", c), 32'(timeout), 32'h0);
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
